// File: rtl/rx_frame_assembler.sv
// Packet assembler: [LEN][payload][CSUM] into a rollback FIFO; optional stats under RX_FRAME_STATS_EN.
// Latency: m_valid rises the cycle after the CSUM byte edge; event pulses are registered (one cycle).
// Backpressure: m_ready stalls reads only; input has none, so packets that cannot fit are dropped (err_ovf).
module rx_frame_assembler #(
    parameter int ADDR_W  = 6,
    parameter int MAX_LEN = 32
) (
    input  logic        clk_x8,
    input  logic        rst,
    input  logic [7:0]  d_in,
    input  logic        d_in_valid,
    input  logic        reframe,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        pkt_ok,
    output logic        err_csum,
    output logic        err_abort,
    output logic        err_len,
    output logic        err_ovf,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_csum,
    output logic [15:0] cnt_abort,
    output logic [15:0] cnt_ovf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DROP} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] wr_q, wr_d, wr_commit_q, wr_commit_d, rd_q, used;
    logic [7:0]      rem_q, rem_d, sum_q, sum_d, sum_total;
    logic [15:0]     free_cnt;
    logic            we;
    logic            ok_d, csum_d, abort_d, len_d, ovf_d;
    logic [8:0]      mem [0:DEPTH-1];
    logic [8:0]      head;

    assign used      = wr_q - rd_q;
    assign free_cnt  = 16'(DEPTH) - {{(15 - ADDR_W){1'b0}}, used};
    assign sum_total = sum_q + d_in;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        wr_commit_d = wr_commit_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        we          = 1'b0;
        ok_d        = 1'b0;
        csum_d      = 1'b0;
        abort_d     = 1'b0;
        len_d       = 1'b0;
        ovf_d       = 1'b0;
        if (reframe) begin
            // A comma wins over a coincident byte; any partial packet is discarded.
            case (state_q)
                PAYLOAD, CHECK: begin
                    wr_d    = wr_commit_q;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
                DROP:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end else if (d_in_valid) begin
            case (state_q)
                IDLE: begin
                    if (d_in == 8'd0 || d_in > MAX_LEN_B) begin
                        len_d   = 1'b1;
                        state_d = DROP;
                    end else if (free_cnt < {8'h00, d_in}) begin
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end else begin
                        rem_d   = d_in;
                        sum_d   = d_in;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    we    = 1'b1;
                    wr_d  = wr_q + 1'b1;
                    sum_d = sum_total;
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = CHECK;
                end
                CHECK: begin
                    if (sum_total == 8'h00) begin
                        wr_commit_d = wr_q;
                        ok_d        = 1'b1;
                    end else begin
                        wr_d   = wr_commit_q;
                        csum_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_x8) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            rem_q       <= 8'd0;
            sum_q       <= 8'd0;
            pkt_ok      <= 1'b0;
            err_csum    <= 1'b0;
            err_abort   <= 1'b0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            wr_commit_q <= wr_commit_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            if (m_valid && m_ready) rd_q <= rd_q + 1'b1;
            pkt_ok      <= ok_d;
            err_csum    <= csum_d;
            err_abort   <= abort_d;
            err_len     <= len_d;
            err_ovf     <= ovf_d;
        end
    end

    always_ff @(posedge clk_x8) begin
        if (we) mem[wr_q[ADDR_W-1:0]] <= {rem_q == 8'd1, d_in};
    end

    // Output is forced to zero while empty so stale RAM never leaks after reset.
    assign head    = mem[rd_q[ADDR_W-1:0]];
    assign m_valid = (wr_commit_q != rd_q);
    assign m_data  = m_valid ? head[7:0] : 8'h00;
    assign m_last  = m_valid & head[8];

`ifdef RX_FRAME_STATS_EN
    always_ff @(posedge clk_x8) begin
        if (rst) begin
            cnt_ok    <= 16'h0000;
            cnt_csum  <= 16'h0000;
            cnt_abort <= 16'h0000;
            cnt_ovf   <= 16'h0000;
        end else begin
            if (ok_d    && cnt_ok    != 16'hFFFF) cnt_ok    <= cnt_ok    + 16'd1;
            if (csum_d  && cnt_csum  != 16'hFFFF) cnt_csum  <= cnt_csum  + 16'd1;
            if (abort_d && cnt_abort != 16'hFFFF) cnt_abort <= cnt_abort + 16'd1;
            if (ovf_d   && cnt_ovf   != 16'hFFFF) cnt_ovf   <= cnt_ovf   + 16'd1;
        end
    end
`else
    assign cnt_ok    = 16'h0000;
    assign cnt_csum  = 16'h0000;
    assign cnt_abort = 16'h0000;
    assign cnt_ovf   = 16'h0000;
`endif

endmodule
